// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide into architectural HI/LO; one bit per cycle,
// results land BITS+1 cycles after start. busy stalls the core, flush aborts.
module muldiv_unit #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [BITS-1:0] din,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] hi,
  output logic [BITS-1:0] lo
);

  localparam int CW = $clog2(BITS);
  localparam logic [CW-1:0] LAST = CW'(BITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            is_div;
  logic            neg_lo;   // negate product (mul) or quotient (div)
  logic            neg_hi;   // remainder takes dividend sign
  logic            div0;
  logic [BITS-1:0] acc_hi;   // product upper half / partial remainder
  logic [BITS-1:0] acc_lo;   // multiplier shifting out / quotient shifting in
  logic [BITS-1:0] opnd;     // multiplicand or divisor

  logic            sgn;
  logic [BITS-1:0] abs_a, abs_b;
  logic [BITS:0]   mul_sum;
  logic [BITS:0]   div_sh, div_diff;
  logic            div_ok;
  logic [2*BITS-1:0] prod, prod_fix;
  logic [BITS-1:0] q_fix, r_fix;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !flush) state_nxt = CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == LAST) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sgn      = ~op[0];
    abs_a    = (sgn && a[BITS-1]) ? -a : a;
    abs_b    = (sgn && b[BITS-1]) ? -b : b;
    mul_sum  = {1'b0, acc_hi} + ({1'b0, opnd} & {(BITS+1){acc_lo[0]}});
    // restoring step: partial remainder stays below the divisor, so bit BITS is the borrow
    div_sh   = {acc_hi, acc_lo[BITS-1]};
    div_diff = div_sh - {1'b0, opnd};
    div_ok   = ~div_diff[BITS];
    prod     = {acc_hi, acc_lo};
    prod_fix = neg_lo ? -prod : prod;
    q_fix    = div0 ? '1 : (neg_lo ? -acc_lo : acc_lo);
    r_fix    = neg_hi ? -acc_hi : acc_hi;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      div0   <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            is_div <= op[1];
            neg_lo <= sgn & (a[BITS-1] ^ b[BITS-1]);
            neg_hi <= sgn & a[BITS-1];
            div0   <= (b == '0);
            acc_hi <= '0;
            acc_lo <= op[1] ? abs_a : abs_b;
            opnd   <= op[1] ? abs_b : abs_a;
            cnt    <= '0;
          end else if (!start) begin
            if (wr_hi) hi <= din;
            if (wr_lo) lo <= din;
          end
        end
        CALC: begin
          if (!flush) begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
              acc_hi <= div_ok ? div_diff[BITS-1:0] : div_sh[BITS-1:0];
              acc_lo <= {acc_lo[BITS-2:0], div_ok};
            end else begin
              acc_hi <= mul_sum[BITS:1];
              acc_lo <= {mul_sum[0], acc_lo[BITS-1:1]};
            end
          end
        end
        FINISH: begin
          if (!flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= r_fix;
              lo <= q_fix;
            end else begin
              hi <= prod_fix[2*BITS-1:BITS];
              lo <= prod_fix[BITS-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
